// File: rtl/tab_update_ctrl_pkg.sv
// Shared constants, pixel-stream field layout and FSM encoding for the table update controller.
package tab_update_ctrl_pkg;

  // Table geometry
  localparam int unsigned TAB_W         = 40;
  localparam int unsigned TAB_H         = 30;
  localparam int unsigned TAB_CELLS_DEF = TAB_W * TAB_H;

  // Pixel stream layout: {RGB[5:0], XC[9:0], YC[9:0]}
  localparam int unsigned RGB_W  = 26;
  localparam int unsigned YC_LSB = 0;
  localparam int unsigned YC_W   = 10;
  localparam int unsigned XC_LSB = 10;
  localparam int unsigned XC_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/tab_req_fifo.sv
// Synchronous first-word-fall-through FIFO holding {address, data} table write requests.
module tab_req_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  // Pointers and occupancy count; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/tab_update_ctrl.sv
// Buffers game-table writes and clears, applying them to the table RAM only during vertical blanking.
module tab_update_ctrl
  import tab_update_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TAB_AW      = 11,
  parameter int unsigned TAB_DW      = 4,
  parameter int unsigned TAB_CELLS   = 1200,
  parameter int unsigned VISIBLEROWS = 480
) (
  input  logic              px_clk,
  input  logic              rst_n,
  input  logic [RGB_W-1:0]  RGBStr_i,
  input  logic              req_valid,
  input  logic [TAB_AW-1:0] req_add,
  input  logic [TAB_DW-1:0] req_dat,
  output logic              req_ready,
  input  logic              req_clear,
  output logic              TabWe,
  output logic [TAB_AW-1:0] TabWAdd,
  output logic [TAB_DW-1:0] TabWDat,
  output logic              frame_tick,
  output logic              busy,
  output logic              bad_add
);

  localparam int unsigned FW = TAB_AW + TAB_DW;

  state_e            state_q, state_d;
  logic [TAB_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic              clear_pend_q, clear_pend_d;
  logic              blank_q, blank_dly_q, blank_d;
  logic              we_d;
  logic [TAB_AW-1:0] wadd_d;
  logic [TAB_DW-1:0] wdat_d;
  logic              in_range, accept, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_dout;
  logic [YC_W-1:0]   yc;
  logic              rgb_unused;

  // Only the row coordinate matters here
  assign yc         = RGBStr_i[YC_LSB +: YC_W];
  assign rgb_unused = ^RGBStr_i[RGB_W-1:YC_W];
  assign blank_d    = (yc >= YC_W'(VISIBLEROWS));

  assign in_range  = (req_add < TAB_AW'(TAB_CELLS));
  assign accept    = req_valid && req_ready;
  assign req_ready = !fifo_full;
  assign busy      = clear_pend_q || (state_q != ST_IDLE) || !fifo_empty;

  // Out-of-range requests are accepted but never stored
  tab_req_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk     (px_clk),
    .rst_n   (rst_n),
    .push_i  (accept && in_range),
    .din_i   ({req_add, req_dat}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state and write-port decode; writes happen only when the previous edge saw blanking
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clear_pend_d = clear_pend_q || req_clear;
    we_d         = 1'b0;
    wadd_d       = '0;
    wdat_d       = '0;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (blank_q && clear_pend_q) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (blank_q && !fifo_empty) begin
          state_d = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        // Without blanking the count is held and the clear resumes next blank
        if (blank_q) begin
          we_d      = 1'b1;
          wadd_d    = clr_cnt_q;
          clr_cnt_d = clr_cnt_q + TAB_AW'(1);
          if (clr_cnt_q == TAB_AW'(TAB_CELLS - 1)) begin
            clr_cnt_d    = '0;
            clear_pend_d = req_clear;
            state_d      = fifo_empty ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!blank_q || fifo_empty) begin
          state_d = ST_IDLE;
        end else begin
          fifo_pop         = 1'b1;
          we_d             = 1'b1;
          {wadd_d, wdat_d} = fifo_dout;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, write port, blank tracking and status pulses
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      clear_pend_q <= 1'b0;
      TabWe        <= 1'b0;
      TabWAdd      <= '0;
      TabWDat      <= '0;
      blank_q      <= 1'b0;
      blank_dly_q  <= 1'b0;
      frame_tick   <= 1'b0;
      bad_add      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_pend_q <= clear_pend_d;
      TabWe        <= we_d;
      TabWAdd      <= wadd_d;
      TabWDat      <= wdat_d;
      blank_q      <= blank_d;
      blank_dly_q  <= blank_q;
      frame_tick   <= blank_q && !blank_dly_q;
      bad_add      <= accept && !in_range;
    end
  end

endmodule
